// File: rtl/tlul_buf_pkg.sv
// Shared types for the per-host TL-UL buffer stage.
// - tl_h2d_t / tl_d2h_t : full TL-UL channel bundles (host->device, device->host)
// - tl_a_pkt_t / tl_d_pkt_t : A/D payloads without valid/ready, stored in the FIFOs
// - A_PKT_W / D_PKT_W : payload widths
// - pack_* / unpack_* : conversion between bundles and payloads
package tlul_buf_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_AUW = 16;
  localparam int unsigned TL_DUW = 16;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [TL_AUW-1:0] a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [TL_DUW-1:0] d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  typedef struct packed {
    tl_a_op_e          opcode;
    logic [2:0]        param;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
    logic [TL_AW-1:0]  address;
    logic [TL_DBW-1:0] mask;
    logic [TL_DW-1:0]  data;
    logic [TL_AUW-1:0] user;
  } tl_a_pkt_t;

  typedef struct packed {
    tl_d_op_e          opcode;
    logic [2:0]        param;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
    logic [TL_DIW-1:0] sink;
    logic [TL_DW-1:0]  data;
    logic [TL_DUW-1:0] user;
    logic              error;
  } tl_d_pkt_t;

  localparam int unsigned A_PKT_W = $bits(tl_a_pkt_t);
  localparam int unsigned D_PKT_W = $bits(tl_d_pkt_t);

  function automatic tl_a_pkt_t pack_a(input tl_h2d_t t);
    tl_a_pkt_t p;
    p.opcode  = t.a_opcode;
    p.param   = t.a_param;
    p.size    = t.a_size;
    p.source  = t.a_source;
    p.address = t.a_address;
    p.mask    = t.a_mask;
    p.data    = t.a_data;
    p.user    = t.a_user;
    return p;
  endfunction

  function automatic tl_h2d_t unpack_a(input tl_a_pkt_t p, input logic valid,
                                       input logic d_ready);
    tl_h2d_t t;
    t.a_valid   = valid;
    t.a_opcode  = p.opcode;
    t.a_param   = p.param;
    t.a_size    = p.size;
    t.a_source  = p.source;
    t.a_address = p.address;
    t.a_mask    = p.mask;
    t.a_data    = p.data;
    t.a_user    = p.user;
    t.d_ready   = d_ready;
    return t;
  endfunction

  function automatic tl_d_pkt_t pack_d(input tl_d2h_t t);
    tl_d_pkt_t p;
    p.opcode = t.d_opcode;
    p.param  = t.d_param;
    p.size   = t.d_size;
    p.source = t.d_source;
    p.sink   = t.d_sink;
    p.data   = t.d_data;
    p.user   = t.d_user;
    p.error  = t.d_error;
    return p;
  endfunction

  function automatic tl_d2h_t unpack_d(input tl_d_pkt_t p, input logic valid,
                                       input logic a_ready);
    tl_d2h_t t;
    t.d_valid  = valid;
    t.d_opcode = p.opcode;
    t.d_param  = p.param;
    t.d_size   = p.size;
    t.d_source = p.source;
    t.d_sink   = p.sink;
    t.d_data   = p.data;
    t.d_user   = p.user;
    t.d_error  = p.error;
    t.a_ready  = a_ready;
    return t;
  endfunction

endpackage

// File: rtl/tlul_buf_fifo.sv
// Registered synchronous FIFO with valid/ready on both sides (no fall-through).
// - clk_i, rst_ni           : clock, asynchronous active-low reset
// - in_valid/in_ready/in_data    : write side; in_ready = !full
// - out_valid/out_ready/out_data : read side; out_valid = !empty
// Pointers carry a wrap bit beside the slot index, so full and empty come
// straight from a pointer compare and any Depth (not only powers of two) works.
// A pop on a full FIFO frees the slot only in the following cycle.
module tlul_buf_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

  typedef struct packed {
    logic            wrap;
    logic [IdxW-1:0] idx;
  } ptr_t;

  if (Depth < 1 || Depth > 16) begin : g_bad_depth
    $error("tlul_buf_fifo: Depth must be in 1..16");
  end

  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t n;
    if (p.idx == LastIdx) begin
      n.idx  = '0;
      n.wrap = ~p.wrap;
    end else begin
      n.idx  = p.idx + IdxW'(1);
      n.wrap = p.wrap;
    end
    return n;
  endfunction

  ptr_t wr_q, rd_q;
  logic full, empty, push, pop;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q.idx == rd_q.idx) && (wr_q.wrap != rd_q.wrap);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = out_valid & out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);
    end
  end

  logic [Width-1:0] mem [Depth];

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array reset-free keeps it plain RAM.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q.idx] <= in_data;
  end

  assign out_data = mem[rd_q.idx];

endmodule

// File: rtl/tlul_host_buf.sv
// Per-host TL-UL buffer stage: host -> tlul_host_buf -> xbar_main.
// - clk_i, rst_ni  : clock, asynchronous active-low reset
// - tl_h_i/tl_h_o  : host side (A request in, D response + a_ready out)
// - tl_d_o/tl_d_i  : crossbar side (A request out, D response + a_ready in)
// - outstanding_o  : requests accepted from the host whose response the host
//                    has not yet taken
// - idle_o         : both FIFOs empty and nothing outstanding
// Host a_ready is withheld once MaxOutstanding requests are in flight, so every
// legitimate response always finds room in the D FIFO. All valid/ready outputs
// come from registered state only.
module tlul_host_buf
  import tlul_buf_pkg::*;
#(
  parameter int unsigned ReqDepth       = 2,
  parameter int unsigned RspDepth       = 2,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned OutW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  tl_h2d_t         tl_h_i,
  output tl_d2h_t         tl_h_o,
  output tl_h2d_t         tl_d_o,
  input  tl_d2h_t         tl_d_i,
  output logic [OutW-1:0] outstanding_o,
  output logic            idle_o
);

  if (RspDepth < MaxOutstanding) begin : g_bad_rsp_depth
    $error("tlul_host_buf: RspDepth must be >= MaxOutstanding");
  end
  if (MaxOutstanding < 1 || MaxOutstanding > 16) begin : g_bad_max_out
    $error("tlul_host_buf: MaxOutstanding must be in 1..16");
  end

  logic [OutW-1:0] cnt_q, cnt_d;
  logic            below_max;
  logic            a_ready;
  logic            a_hs, d_hs;

  // A channel FIFO
  logic      afifo_in_ready, afifo_out_valid;
  tl_a_pkt_t a_pkt_in, a_pkt_out;

  // D channel FIFO
  logic      dfifo_in_ready, dfifo_out_valid;
  tl_d_pkt_t d_pkt_in, d_pkt_out;

  assign below_max = (cnt_q < OutW'(MaxOutstanding));
  assign a_ready   = afifo_in_ready & below_max;
  assign a_pkt_in  = pack_a(tl_h_i);
  assign d_pkt_in  = pack_d(tl_d_i);

  // Gating in_valid with below_max makes the FIFO push identical to the host
  // handshake, so the counter and the FIFO can never disagree.
  tlul_buf_fifo #(
    .Width (A_PKT_W),
    .Depth (ReqDepth)
  ) u_afifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (tl_h_i.a_valid & below_max),
    .in_ready  (afifo_in_ready),
    .in_data   (a_pkt_in),
    .out_valid (afifo_out_valid),
    .out_ready (tl_d_i.a_ready),
    .out_data  (a_pkt_out)
  );

  tlul_buf_fifo #(
    .Width (D_PKT_W),
    .Depth (RspDepth)
  ) u_dfifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (tl_d_i.d_valid),
    .in_ready  (dfifo_in_ready),
    .in_data   (d_pkt_in),
    .out_valid (dfifo_out_valid),
    .out_ready (tl_h_i.d_ready),
    .out_data  (d_pkt_out)
  );

  assign tl_d_o = unpack_a(a_pkt_out, afifo_out_valid, dfifo_in_ready);
  assign tl_h_o = unpack_d(d_pkt_out, dfifo_out_valid, a_ready);

  assign a_hs = tl_h_i.a_valid & a_ready;
  assign d_hs = dfifo_out_valid & tl_h_i.d_ready;

  // NOTE: cnt_d is given its hold value before any branch so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({a_hs, d_hs})
      2'b10:   cnt_d = cnt_q + OutW'(1);
      // A response with nothing outstanding is a protocol error: forward it
      // but keep the counter at zero.
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - OutW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign outstanding_o = cnt_q;
  assign idle_o        = ~afifo_out_valid & ~dfifo_out_valid & (cnt_q == '0);

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= OutW'(MaxOutstanding));

  a_no_dec_at_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
    d_hs && !a_hs |-> cnt_q != '0);

  a_no_spurious_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tl_d_i.d_valid && dfifo_in_ready |-> cnt_q != '0);

endmodule

// File: tb/tb_tlul_host_buf.sv
module tb_tlul_host_buf;
  import tlul_buf_pkg::*;

  localparam int unsigned ReqDepth = 2;
  localparam int unsigned RspDepth = 2;
  localparam int unsigned MaxOut   = 2;
  localparam int unsigned OutW     = $clog2(MaxOut + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tl_h2d_t         tl_h_i, tl_d_o;
  tl_d2h_t         tl_h_o, tl_d_i;
  logic [OutW-1:0] outstanding;
  logic            idle;

  tlul_host_buf #(
    .ReqDepth       (ReqDepth),
    .RspDepth       (RspDepth),
    .MaxOutstanding (MaxOut)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tl_h_i        (tl_h_i),
    .tl_h_o        (tl_h_o),
    .tl_d_o        (tl_d_o),
    .tl_d_i        (tl_d_i),
    .outstanding_o (outstanding),
    .idle_o        (idle)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: two plain queues and an in-flight count.
  tl_h2d_t m_aq[$];
  tl_d2h_t m_dq[$];
  int      m_cnt = 0;

  always @(negedge clk) begin : cmp
    bit      exp_ar, exp_dr, a_acc, a_pop, d_push, d_pop;
    tl_h2d_t ea;
    tl_d2h_t ed;
    if (!rst_n) begin
      m_aq.delete();
      m_dq.delete();
      m_cnt = 0;
      check("rst_a_valid", 256'(tl_d_o.a_valid), 256'(0));
      check("rst_d_valid", 256'(tl_h_o.d_valid), 256'(0));
      check("rst_outstanding", 256'(outstanding), 256'(0));
    end else begin
      exp_ar = (m_aq.size() < ReqDepth) && (m_cnt < MaxOut);
      exp_dr = (m_dq.size() < RspDepth);
      check("m_a_ready", 256'(tl_h_o.a_ready), 256'(exp_ar));
      check("m_d_ready", 256'(tl_d_o.d_ready), 256'(exp_dr));
      check("m_outstanding", 256'(outstanding), 256'(m_cnt));
      check("m_idle", 256'(idle),
            256'(m_aq.size() == 0 && m_dq.size() == 0 && m_cnt == 0));
      if (m_aq.size() > 0) begin
        ea = m_aq[0];
        ea.a_valid = 1'b1;
        ea.d_ready = exp_dr;
        check("m_tl_d_o", 256'(tl_d_o), 256'(ea));
      end else begin
        check("m_a_valid", 256'(tl_d_o.a_valid), 256'(0));
      end
      if (m_dq.size() > 0) begin
        ed = m_dq[0];
        ed.d_valid = 1'b1;
        ed.a_ready = exp_ar;
        check("m_tl_h_o", 256'(tl_h_o), 256'(ed));
      end else begin
        check("m_d_valid", 256'(tl_h_o.d_valid), 256'(0));
      end
      // Advance to the state after the coming clock edge.
      a_acc  = tl_h_i.a_valid && exp_ar;
      a_pop  = (m_aq.size() > 0) && tl_d_i.a_ready;
      d_push = tl_d_i.d_valid && exp_dr;
      d_pop  = (m_dq.size() > 0) && tl_h_i.d_ready;
      if (a_pop)  void'(m_aq.pop_front());
      if (a_acc)  m_aq.push_back(tl_h_i);
      if (d_pop)  void'(m_dq.pop_front());
      if (d_push) m_dq.push_back(tl_d_i);
      if (a_acc && !d_pop) m_cnt++;
      else if (d_pop && !a_acc && m_cnt > 0) m_cnt--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input tl_a_op_e op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [7:0] src);
    tl_h_i.a_valid   = 1'b1;
    tl_h_i.a_opcode  = op;
    tl_h_i.a_param   = 3'd0;
    tl_h_i.a_size    = 2'd2;
    tl_h_i.a_source  = src;
    tl_h_i.a_address = addr;
    tl_h_i.a_mask    = 4'hF;
    tl_h_i.a_data    = data;
    tl_h_i.a_user    = 16'h0;
  endtask

  task automatic drive_d(input tl_d_op_e op, input logic [7:0] src,
                         input logic [31:0] data);
    tl_d_i.d_valid  = 1'b1;
    tl_d_i.d_opcode = op;
    tl_d_i.d_param  = 3'd0;
    tl_d_i.d_size   = 2'd2;
    tl_d_i.d_source = src;
    tl_d_i.d_sink   = 1'b0;
    tl_d_i.d_data   = data;
    tl_d_i.d_user   = 16'h0;
    tl_d_i.d_error  = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!idle && n < limit) begin
      tick();
      n++;
    end
    check("wait_idle", 256'(idle), 256'(1));
  endtask

  function automatic tl_h2d_t rand_a();
    tl_h2d_t t = '0;
    t.a_valid = 1'b1;
    case ($urandom_range(0, 2))
      0:       t.a_opcode = PutFullData;
      1:       t.a_opcode = PutPartialData;
      default: t.a_opcode = Get;
    endcase
    t.a_param   = 3'($urandom);
    t.a_size    = 2'($urandom);
    t.a_source  = 8'($urandom);
    t.a_address = $urandom;
    t.a_mask    = 4'($urandom);
    t.a_data    = $urandom;
    t.a_user    = 16'($urandom);
    return t;
  endfunction

  function automatic tl_d2h_t rand_d(input logic [7:0] src);
    tl_d2h_t t = '0;
    t.d_valid  = 1'b1;
    t.d_opcode = ($urandom_range(0, 1) == 0) ? AccessAck : AccessAckData;
    t.d_param  = 3'($urandom);
    t.d_size   = 2'($urandom);
    t.d_source = src;
    t.d_sink   = 1'($urandom);
    t.d_data   = $urandom;
    t.d_user   = 16'($urandom);
    t.d_error  = 1'($urandom);
    return t;
  endfunction

  // Sources of requests the crossbar has taken but not yet answered.
  logic [7:0] xq[$];

  task automatic run_random(input int cycles, input bit gen_new);
    bit         h_acc, x_acc, x_rsp;
    logic [7:0] src;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      h_acc = tl_h_i.a_valid && tl_h_o.a_ready;
      x_acc = tl_d_o.a_valid && tl_d_i.a_ready;
      x_rsp = tl_d_i.d_valid && tl_d_o.d_ready;
      src   = tl_d_o.a_source;
      tick();
      if (x_acc) xq.push_back(src);
      if (x_rsp) tl_d_i.d_valid = 1'b0;
      if (!tl_d_i.d_valid && xq.size() > 0 &&
          (!gen_new || $urandom_range(0, 99) < 60)) begin
        tl_d_i = rand_d(xq.pop_front());
      end
      if (h_acc) tl_h_i.a_valid = 1'b0;
      if (gen_new && !tl_h_i.a_valid && $urandom_range(0, 99) < 50)
        tl_h_i = rand_a();
      tl_d_i.a_ready = !gen_new || ($urandom_range(0, 99) < 70);
      tl_h_i.d_ready = !gen_new || ($urandom_range(0, 99) < 70);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tl_h_i = '0;
    tl_d_i = '0;
    tl_h_i.d_ready = 1'b1;
    tl_d_i.a_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_a_ready", 256'(tl_h_o.a_ready), 256'(1));
    check("post_rst_a_valid", 256'(tl_d_o.a_valid), 256'(0));
    check("post_rst_d_ready", 256'(tl_d_o.d_ready), 256'(1));
    check("post_rst_outstanding", 256'(outstanding), 256'(0));
    check("post_rst_idle", 256'(idle), 256'(1));

    // Single PutFullData and its AccessAck.
    drive_a(PutFullData, 32'h1000_0040, 32'hDEAD_BEEF, 8'd3);
    tick();
    tl_h_i.a_valid = 1'b0;
    check("put_a_valid", 256'(tl_d_o.a_valid), 256'(1));
    check("put_addr", 256'(tl_d_o.a_address), 256'(32'h1000_0040));
    check("put_data", 256'(tl_d_o.a_data), 256'(32'hDEAD_BEEF));
    check("put_source", 256'(tl_d_o.a_source), 256'(3));
    check("put_opcode", 256'(tl_d_o.a_opcode), 256'(PutFullData));
    check("put_outst_1", 256'(outstanding), 256'(1));
    tick();
    check("put_drained", 256'(tl_d_o.a_valid), 256'(0));
    drive_d(AccessAck, 8'd3, 32'h0);
    tick();
    tl_d_i.d_valid = 1'b0;
    check("ack_d_valid", 256'(tl_h_o.d_valid), 256'(1));
    check("ack_source", 256'(tl_h_o.d_source), 256'(3));
    check("ack_opcode", 256'(tl_h_o.d_opcode), 256'(AccessAck));
    tick();
    check("ack_outst_0", 256'(outstanding), 256'(0));
    check("ack_idle", 256'(idle), 256'(1));

    // Outstanding cap: two Gets in flight block a third.
    drive_a(Get, 32'h2000_0000, 32'h0, 8'd5);
    tick();
    check("cap_outst_1", 256'(outstanding), 256'(1));
    tl_h_i.a_source = 8'd6;
    tick();
    check("cap_outst_2", 256'(outstanding), 256'(2));
    check("cap_a_ready_0", 256'(tl_h_o.a_ready), 256'(0));
    tl_h_i.a_source = 8'd7;
    repeat (3) tick();
    check("cap_third_waits", 256'(outstanding), 256'(2));
    check("cap_still_blocked", 256'(tl_h_o.a_ready), 256'(0));
    drive_d(AccessAckData, 8'd5, 32'h5555_0000);
    tick();
    tl_d_i.d_valid = 1'b0;
    check("cap_rsp_buffered", 256'(tl_h_o.a_ready), 256'(0));
    tick();
    check("cap_a_ready_back", 256'(tl_h_o.a_ready), 256'(1));
    check("cap_outst_dec", 256'(outstanding), 256'(1));
    tick();
    tl_h_i.a_valid = 1'b0;
    check("cap_third_taken", 256'(outstanding), 256'(2));
    drive_d(AccessAckData, 8'd6, 32'h6666_0000);
    tick();
    tl_d_i.d_source = 8'd7;
    tick();
    tl_d_i.d_valid = 1'b0;
    wait_idle(20);

    // Request FIFO fills while the crossbar stalls for 10 cycles.
    tl_d_i.a_ready = 1'b0;
    drive_a(PutFullData, 32'h3000_0000, 32'h0000_00A0, 8'd1);
    tick();
    tl_h_i.a_data = 32'h0000_00A1;
    tick();
    tl_h_i.a_data = 32'h0000_00A2;
    check("fill_a_ready_0", 256'(tl_h_o.a_ready), 256'(0));
    check("fill_head", 256'(tl_d_o.a_data), 256'(32'h0000_00A0));
    repeat (8) tick();
    tl_h_i.a_valid = 1'b0;
    tl_d_i.a_ready = 1'b1;
    check("fill_head_held", 256'(tl_d_o.a_data), 256'(32'h0000_00A0));
    tick();
    check("drain_second_v", 256'(tl_d_o.a_valid), 256'(1));
    check("drain_second", 256'(tl_d_o.a_data), 256'(32'h0000_00A1));
    tick();
    check("drain_empty", 256'(tl_d_o.a_valid), 256'(0));
    drive_d(AccessAck, 8'd1, 32'h0);
    repeat (2) tick();
    tl_d_i.d_valid = 1'b0;
    wait_idle(20);

    // Response FIFO fills while the host stalls d_ready.
    tl_h_i.d_ready = 1'b0;
    drive_a(Get, 32'h4000_0000, 32'h0, 8'd1);
    tick();
    tl_h_i.a_source = 8'd2;
    tick();
    tl_h_i.a_valid = 1'b0;
    drive_d(AccessAckData, 8'd1, 32'h0000_0011);
    tick();
    drive_d(AccessAckData, 8'd2, 32'h0000_0022);
    tick();
    tl_d_i.d_valid = 1'b0;
    check("dfull_d_ready_0", 256'(tl_d_o.d_ready), 256'(0));
    check("dfull_first", 256'(tl_h_o.d_data), 256'(32'h0000_0011));
    tl_h_i.d_ready = 1'b1;
    tick();
    check("dfull_second", 256'(tl_h_o.d_data), 256'(32'h0000_0022));
    check("dfull_outst_1", 256'(outstanding), 256'(1));
    drive_a(Get, 32'h4000_0010, 32'h0, 8'd9);
    tick();
    tl_h_i.a_valid = 1'b0;
    check("both_hs_outst", 256'(outstanding), 256'(1));
    check("both_hs_d_empty", 256'(tl_h_o.d_valid), 256'(0));
    drive_d(AccessAckData, 8'd9, 32'h0000_0099);
    tick();
    tl_d_i.d_valid = 1'b0;
    wait_idle(20);

    // Reset with one request queued and outstanding.
    tl_d_i.a_ready = 1'b0;
    drive_a(Get, 32'h5000_0000, 32'h0, 8'd4);
    tick();
    tl_h_i.a_valid = 1'b0;
    check("pre_rst_queued", 256'(tl_d_o.a_valid), 256'(1));
    check("pre_rst_outst", 256'(outstanding), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_a_valid", 256'(tl_d_o.a_valid), 256'(0));
    check("mid_rst_d_valid", 256'(tl_h_o.d_valid), 256'(0));
    check("mid_rst_outst", 256'(outstanding), 256'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tl_d_i.a_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_a", 256'(tl_d_o.a_valid), 256'(0));
    end
    check("post_rst2_idle", 256'(idle), 256'(1));

    // Randomised traffic against the model, then drain.
    xq.delete();
    run_random(2000, 1'b1);
    run_random(100, 1'b0);
    check("final_idle", 256'(idle), 256'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
